// File: rtl/cam_pkg.sv
// Shared definitions for the DVP capture path: byte width, FSM encoding, pixel packing.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package cam_pkg;

    localparam int DVP_BYTE_W = 8;

    typedef enum logic {
        ST_SYNC  = 1'b0,   // waiting for a full vsync high->low
        ST_FRAME = 1'b1    // inside a frame, counting lines
    } cap_state_t;

    // RGB565 -> RGB444: keep the top 4 bits of each colour field.
    function automatic logic [11:0] rgb565_to_444(input logic [2*DVP_BYTE_W-1:0] p);
        return {p[15:12], p[10:7], p[4:1]};
    endfunction

endpackage

// File: rtl/dvp_byte_pair.sv
// DVP input register plus hi/lo byte pairing into 16-bit pixels; also re-times vsync and href edges.
// Latency: pix_vld/pix appear 1 pclk after the edge that registers the low byte (2 register stages from pins).
// Backpressure: none; the camera cannot be stalled, every pixel is emitted as it completes.
// Ports: pclk, rst_n; vsync/href/d from camera pins;
//        vsync_s, line_start, line_end, pix_vld, pix all share the same pipeline stage.
module dvp_byte_pair
    import cam_pkg::*;
(
    input  logic                    pclk,
    input  logic                    rst_n,
    input  logic                    vsync,
    input  logic                    href,
    input  logic [DVP_BYTE_W-1:0]   d,
    output logic                    vsync_s,
    output logic                    line_start,
    output logic                    line_end,
    output logic                    pix_vld,
    output logic [2*DVP_BYTE_W-1:0] pix
);

    logic                  vsync_r;
    logic                  href_r;
    logic                  href_p;
    logic [DVP_BYTE_W-1:0] d_r;
    logic [DVP_BYTE_W-1:0] hi_q;
    logic                  phase;      // 1: the byte now in d_r is the low half of a pixel
    logic                  href_rise;
    logic                  href_fall;
    logic                  byte_lo;

    assign href_rise = href_r & ~href_p;
    assign href_fall = ~href_r & href_p;
    // The first byte after href rise is always a high byte, whatever phase was left over.
    assign byte_lo   = href_r & ~href_rise & phase;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_r    <= 1'b0;
            href_r     <= 1'b0;
            href_p     <= 1'b0;
            d_r        <= '0;
            hi_q       <= '0;
            phase      <= 1'b0;
            vsync_s    <= 1'b0;
            line_start <= 1'b0;
            line_end   <= 1'b0;
            pix_vld    <= 1'b0;
            pix        <= '0;
        end else begin
            vsync_r <= vsync;
            href_r  <= href;
            d_r     <= d;
            href_p  <= href_r;

            if (!href_r) begin
                phase <= 1'b0;
            end else if (href_rise) begin
                phase <= 1'b1;
            end else begin
                phase <= ~phase;
            end

            // A high byte left unpaired at href fall is simply overwritten by the next line.
            if (href_r && !byte_lo) begin
                hi_q <= d_r;
            end

            vsync_s    <= vsync_r;
            line_start <= href_rise;
            line_end   <= href_fall;
            pix_vld    <= byte_lo;
            if (byte_lo) begin
                pix <= {hi_q, d_r};
            end
        end
    end

endmodule

// File: rtl/dvp_capture_dec.sv
// DVP camera capture: RGB565 byte pairs -> decimated, windowed RGB444 frame-buffer writes.
// Latency: we rises 2 pclk after the edge that samples the low byte on d; addr/dout valid with we.
// Backpressure: none; writes beyond DEPTH are dropped and flagged through sticky overflow.
// Ports: pclk, rst_n (async, active low); vsync, href, d, enable in;
//        addr, dout, we, bank, frame_done, overflow out.
// Optional: define DVP_CAPTURE_STATS_EN to add line_len[11:0] and frame_lines[10:0].
module dvp_capture_dec
    import cam_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int H_DECIM    = 2,
    parameter int V_DECIM    = 2,
    parameter int ADDR_W     = 17,
    parameter int DOUBLE_BUF = 0
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    input  logic                  vsync,
    input  logic                  href,
    input  logic [DVP_BYTE_W-1:0] d,
    input  logic                  enable,
    output logic [ADDR_W-1:0]     addr,
    output logic [11:0]           dout,
    output logic                  we,
    output logic                  bank,
    output logic                  frame_done,
    output logic                  overflow
`ifdef DVP_CAPTURE_STATS_EN
    ,
    output logic [11:0]           line_len,
    output logic [10:0]           frame_lines
`endif
);

    localparam int     H_OUT    = H_ACTIVE / H_DECIM;
    localparam int     V_OUT    = V_ACTIVE / V_DECIM;
    localparam int     DEPTH    = H_OUT * V_OUT;
    localparam int     IDX_BITS = (DOUBLE_BUF != 0) ? ADDR_W - 1 : ADDR_W;
    localparam longint CAP      = longint'(1) << IDX_BITS;
    localparam int     PW       = $clog2(H_ACTIVE + 1);
    localparam int     LW       = $clog2(V_ACTIVE + 1);

    localparam logic [PW-1:0]   H_LIM     = PW'(H_ACTIVE);
    localparam logic [LW-1:0]   V_LIM     = LW'(V_ACTIVE);
    localparam logic [2:0]      H_RLD     = 3'(H_DECIM - 1);
    localparam logic [2:0]      V_RLD     = 3'(V_DECIM - 1);
    localparam logic [ADDR_W:0] DEPTH_IDX = (ADDR_W + 1)'(DEPTH);

    generate
        if (DEPTH < 1 || longint'(DEPTH) > CAP) begin : g_bad_depth
            $error("dvp_capture_dec: DEPTH does not fit the write address");
        end
        if (H_DECIM < 1 || H_DECIM > 8 || V_DECIM < 1 || V_DECIM > 8) begin : g_bad_decim
            $error("dvp_capture_dec: decimation factors must be 1..8");
        end
    endgenerate

    // ------------------------------------------------------------------ byte pairing
    logic                    vsync_s;
    logic                    line_start;
    logic                    line_end;
    logic                    pix_vld;
    logic [2*DVP_BYTE_W-1:0] pix;

    dvp_byte_pair u_pair (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .href       (href),
        .d          (d),
        .vsync_s    (vsync_s),
        .line_start (line_start),
        .line_end   (line_end),
        .pix_vld    (pix_vld),
        .pix        (pix)
    );

    // ------------------------------------------------------------------ frame FSM
    cap_state_t state_q;
    cap_state_t state_d;
    logic       vsync_p;
    logic       v_rise;
    logic       v_fall;
    logic       frame_start;
    logic       frame_end;
    logic       in_frame;

    // vsync_p resets low, so a fall is only seen after vsync has been observed high post-reset.
    assign v_rise = vsync_s & ~vsync_p;
    assign v_fall = ~vsync_s & vsync_p;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SYNC;
            vsync_p <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_p <= vsync_s;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (v_fall) begin
                    state_d     = ST_FRAME;
                    frame_start = 1'b1;
                end
            end
            ST_FRAME: begin
                if (v_rise) begin
                    state_d   = ST_SYNC;
                    frame_end = 1'b1;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    // vsync rising takes priority over anything href is doing in the same cycle.
    assign in_frame = (state_q == ST_FRAME) && !v_rise;

    // ------------------------------------------------------------------ counters and writes
    logic [PW-1:0]   pix_cnt;
    logic [LW-1:0]   line_cnt;
    logic [2:0]      hdc;        // 0 marks a kept pixel
    logic [2:0]      vdc;        // 0 marks a kept line
    logic [ADDR_W:0] idx;        // next write index; one spare bit so DEPTH itself is representable
    logic            cap_en;
    logic            bank_q;
    logic            write_ok;
    logic [ADDR_W-1:0] wr_addr;

    generate
        if (DOUBLE_BUF != 0) begin : g_bank_addr
            assign wr_addr = {bank_q, idx[ADDR_W-2:0]};
        end else begin : g_flat_addr
            assign wr_addr = idx[ADDR_W-1:0];
        end
    endgenerate

    assign write_ok = cap_en && (pix_cnt < H_LIM) && (line_cnt < V_LIM)
                   && (hdc == 3'd0) && (vdc == 3'd0);

    assign bank = bank_q;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            dout       <= '0;
            we         <= 1'b0;
            bank_q     <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            hdc        <= '0;
            vdc        <= '0;
            idx        <= '0;
            cap_en     <= 1'b0;
        end else begin
            we         <= 1'b0;
            frame_done <= 1'b0;

            if (frame_start) begin
                idx      <= '0;
                overflow <= 1'b0;
                line_cnt <= '0;
                vdc      <= '0;
                pix_cnt  <= '0;
                hdc      <= '0;
                cap_en   <= enable;
            end

            if (frame_end) begin
                frame_done <= cap_en;
                if (DOUBLE_BUF != 0 && cap_en) begin
                    bank_q <= ~bank_q;
                end
            end

            if (in_frame) begin
                if (line_start) begin
                    pix_cnt <= '0;
                    hdc     <= '0;
                end

                if (pix_vld) begin
                    if (write_ok) begin
                        if (idx == DEPTH_IDX) begin
                            overflow <= 1'b1;   // no wrap: addr keeps the last written location
                        end else begin
                            we   <= 1'b1;
                            addr <= wr_addr;
                            dout <= rgb565_to_444(pix);
                            idx  <= idx + (ADDR_W + 1)'(1);
                        end
                    end
                    // Saturate so over-long lines cannot wrap back into the window.
                    if (pix_cnt != H_LIM) begin
                        pix_cnt <= pix_cnt + PW'(1);
                    end
                    hdc <= (hdc == 3'd0) ? H_RLD : hdc - 3'd1;
                end

                if (line_end) begin
                    if (line_cnt != V_LIM) begin
                        line_cnt <= line_cnt + LW'(1);
                    end
                    vdc <= (vdc == 3'd0) ? V_RLD : vdc - 3'd1;
                end
            end
        end
    end

`ifdef DVP_CAPTURE_STATS_EN
    // ------------------------------------------------------------------ line/frame statistics
    logic [11:0] line_px;
    logic [10:0] frm_ln;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            line_px     <= '0;
            frm_ln      <= '0;
            line_len    <= '0;
            frame_lines <= '0;
        end else begin
            if (frame_start) begin
                line_px <= '0;
                frm_ln  <= '0;
            end
            if (frame_end) begin
                frame_lines <= frm_ln;
            end
            if (in_frame) begin
                if (line_start) begin
                    line_px <= '0;
                end else if (pix_vld && line_px != 12'hFFF) begin
                    line_px <= line_px + 12'd1;
                end
                if (line_end) begin
                    line_len <= line_px;
                    if (frm_ln != 11'h7FF) begin
                        frm_ln <= frm_ln + 11'd1;
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dvp_capture_dec.sv
// Bench for dvp_capture_dec: three parameterisations share one camera stimulus.
// a: 8x4 no decimation; b: 8x4 decim 2/2 double-buffered; c: 4x5 decim 1/2 (DEPTH 8, overflows).
module tb_dvp_capture_dec;

    logic       pclk = 1'b0;
    logic       rst_n;
    logic       vsync = 1'b0;
    logic       href = 1'b0;
    logic [7:0] d = 8'h00;
    logic       enable = 1'b0;

    always #5 pclk = ~pclk;

    logic [4:0]  addr_a;
    logic [3:0]  addr_b, addr_c;
    logic [11:0] dout_a, dout_b, dout_c;
    logic        we_a, we_b, we_c;
    logic        bank_a, bank_b, bank_c;
    logic        fd_a, fd_b, fd_c;
    logic        ovf_a, ovf_b, ovf_c;
`ifdef DVP_CAPTURE_STATS_EN
    logic [11:0] ll_a, ll_b, ll_c;
    logic [10:0] fl_a, fl_b, fl_c;
`endif

    dvp_capture_dec #(.H_ACTIVE(8), .V_ACTIVE(4), .H_DECIM(1), .V_DECIM(1),
                      .ADDR_W(5), .DOUBLE_BUF(0)) dut_a (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d), .enable(enable),
        .addr(addr_a), .dout(dout_a), .we(we_a), .bank(bank_a),
        .frame_done(fd_a), .overflow(ovf_a)
`ifdef DVP_CAPTURE_STATS_EN
        , .line_len(ll_a), .frame_lines(fl_a)
`endif
    );

    dvp_capture_dec #(.H_ACTIVE(8), .V_ACTIVE(4), .H_DECIM(2), .V_DECIM(2),
                      .ADDR_W(4), .DOUBLE_BUF(1)) dut_b (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d), .enable(enable),
        .addr(addr_b), .dout(dout_b), .we(we_b), .bank(bank_b),
        .frame_done(fd_b), .overflow(ovf_b)
`ifdef DVP_CAPTURE_STATS_EN
        , .line_len(ll_b), .frame_lines(fl_b)
`endif
    );

    dvp_capture_dec #(.H_ACTIVE(4), .V_ACTIVE(5), .H_DECIM(1), .V_DECIM(2),
                      .ADDR_W(4), .DOUBLE_BUF(0)) dut_c (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d), .enable(enable),
        .addr(addr_c), .dout(dout_c), .we(we_c), .bank(bank_c),
        .frame_done(fd_c), .overflow(ovf_c)
`ifdef DVP_CAPTURE_STATS_EN
        , .line_len(ll_c), .frame_lines(fl_c)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] pk(input logic [15:0] p);
        return {p[15:12], p[10:7], p[4:1]};
    endfunction

    // Frame context used by the write monitor to predict each write.
    logic [15:0] base = 16'h0000;
    int          npix = 8;
    int          ja = 0, jb = 0, jc = 0;
    int          done_a = 0, done_b = 0, done_c = 0;
    logic        bank_m = 1'b0;

    always @(negedge pclk) begin
        if (we_a === 1'b1) begin
            chk("a_addr", addr_a, ja);
            chk("a_dout", dout_a, pk(base + 16'((ja / 8) * npix + ja % 8)));
            ja++;
        end
        if (we_b === 1'b1) begin
            chk("b_addr", addr_b, 32'(bank_m) * 8 + 32'(jb % 8));
            chk("b_bank", bank_b, bank_m);
            chk("b_dout", dout_b, pk(base + 16'(2 * (jb / 4) * npix + 2 * (jb % 4))));
            jb++;
        end
        if (we_c === 1'b1) begin
            chk("c_addr", addr_c, jc);
            chk("c_dout", dout_c, pk(base + 16'(2 * (jc / 4) * npix + jc % 4)));
            jc++;
        end
        if (fd_a === 1'b1) done_a++;
        if (fd_b === 1'b1) done_b++;
        if (fd_c === 1'b1) done_c++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic drive_line(input int line, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            logic [15:0] p;
            p    = base + 16'(line * npix + i / 2);
            href = 1'b1;
            if (nbytes % 2 == 1 && i == nbytes - 1) d = 8'hEE;
            else d = (i % 2 == 0) ? p[15:8] : p[7:0];
            tick(1);
        end
        href = 1'b0;
        d    = 8'h00;
        tick(3);
    endtask

    task automatic clear_counts();
        ja = 0; jb = 0; jc = 0;
        done_a = 0; done_b = 0; done_c = 0;
    endtask

    task automatic start_frame(input logic [15:0] b, input int nb, input logic en);
        base   = b;
        npix   = nb / 2;
        enable = en;
        clear_counts();
        vsync = 1'b1;
        tick(4);
        vsync = 1'b0;
        tick(3);
    endtask

    task automatic end_frame(input logic en);
        vsync = 1'b1;
        tick(8);
        if (en) bank_m = ~bank_m;
    endtask

    typedef struct {
        int          lines;
        int          nbytes;
        logic        en;
        logic [15:0] b;
        int          a_we;
        int          b_we;
        int          c_we;
        int          done;
        logic        c_ovf;
    } vec_t;

    vec_t tbl[6];

    initial begin
        //           lines bytes en  base      a_we b_we c_we done ovf
        tbl[0] = '{ 4,    16,   1, 16'h1234, 32,  8,   8,   1,   0 };
        tbl[1] = '{ 4,    16,   1, 16'h0F0F, 32,  8,   8,   1,   0 };
        tbl[2] = '{ 12,   16,   1, 16'hA5A5, 32,  8,   8,   1,   1 };
        tbl[3] = '{ 4,    17,   1, 16'h8001, 32,  8,   8,   1,   0 };
        tbl[4] = '{ 4,    16,   0, 16'h7777, 0,   0,   0,   0,   0 };
        tbl[5] = '{ 2,    20,   1, 16'h4321, 16,  4,   4,   1,   0 };

        // ---- reset state
        rst_n = 1'b0;
        tick(3);
        chk("rst_addr_a", addr_a, 0);
        chk("rst_dout_a", dout_a, 0);
        chk("rst_we_a", we_a, 0);
        chk("rst_fd_a", fd_a, 0);
        chk("rst_ovf_a", ovf_a, 0);
        chk("rst_bank_b", bank_b, 0);
        chk("rst_addr_b", addr_b, 0);
        chk("rst_ovf_c", ovf_c, 0);
        rst_n = 1'b1;
        tick(3);

        // ---- table-driven frames
        for (int f = 0; f < 6; f++) begin
            start_frame(tbl[f].b, tbl[f].nbytes, tbl[f].en);
            for (int l = 0; l < tbl[f].lines; l++) drive_line(l, tbl[f].nbytes);
            end_frame(tbl[f].en);
            chk($sformatf("f%0d_a_writes", f), ja, tbl[f].a_we);
            chk($sformatf("f%0d_b_writes", f), jb, tbl[f].b_we);
            chk($sformatf("f%0d_c_writes", f), jc, tbl[f].c_we);
            chk($sformatf("f%0d_a_done", f), done_a, tbl[f].done);
            chk($sformatf("f%0d_b_done", f), done_b, tbl[f].done);
            chk($sformatf("f%0d_c_done", f), done_c, tbl[f].done);
            chk($sformatf("f%0d_c_ovf", f), ovf_c, tbl[f].c_ovf);
            chk($sformatf("f%0d_a_ovf", f), ovf_a, 0);
            chk($sformatf("f%0d_b_bank", f), bank_b, bank_m);
            if (tbl[f].c_we > 0) chk($sformatf("f%0d_c_addr_hold", f), addr_c, tbl[f].c_we - 1);
        end

        // ---- write latency: low byte sampled at edge E0, we only between E2 and E3
        start_frame(16'h00F0, 2, 1'b1);
        href = 1'b1;
        d    = 8'h00;
        tick(1);
        d = 8'hF0;
        tick(1);
        href = 1'b0;
        d    = 8'h00;
        chk("lat_after_e0", we_a, 0);
        tick(1);
        chk("lat_after_e1", we_a, 0);
        tick(1);
        chk("lat_after_e2", we_a, 1);
        tick(1);
        chk("lat_after_e3", we_a, 0);
        tick(3);
        end_frame(1'b1);
        chk("lat_a_writes", ja, 1);
        chk("lat_a_done", done_a, 1);

        // ---- reset mid-frame: rest of that frame is discarded
        start_frame(16'h2000, 16, 1'b1);
        drive_line(0, 16);
        chk("mid_pre_writes", ja, 8);
        rst_n = 1'b0;
        tick(2);
        chk("mid_rst_addr_a", addr_a, 0);
        chk("mid_rst_bank_b", bank_b, 0);
        bank_m = 1'b0;
        clear_counts();
        rst_n = 1'b1;
        drive_line(1, 16);
        drive_line(2, 16);
        end_frame(1'b0);
        chk("mid_post_writes", ja, 0);
        chk("mid_post_done", done_a, 0);
        start_frame(16'h3000, 16, 1'b1);
        for (int l = 0; l < 4; l++) drive_line(l, 16);
        end_frame(1'b1);
        chk("next_a_writes", ja, 32);
        chk("next_b_writes", jb, 8);
        chk("next_a_done", done_a, 1);
        chk("next_b_bank", bank_b, bank_m);

        // ---- vsync rising while href is high: the line is abandoned at once
        start_frame(16'h5000, 16, 1'b1);
        for (int i = 0; i < 12; i++) begin
            logic [15:0] p;
            p    = base + 16'(i / 2);
            href = 1'b1;
            d    = (i % 2 == 0) ? p[15:8] : p[7:0];
            if (i == 6) vsync = 1'b1;
            tick(1);
        end
        href = 1'b0;
        d    = 8'h00;
        tick(8);
        bank_m = ~bank_m;
        chk("vh_a_writes", ja, 3);
        chk("vh_b_writes", jb, 2);
        chk("vh_c_writes", jc, 3);
        chk("vh_a_done", done_a, 1);
        chk("vh_b_bank", bank_b, bank_m);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
